// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control sequencer:
// FSM states, instruction classes, opcodes and datapath mux selects.
package riscv_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    CLS_NONE   = 4'd0,
    CLS_OP     = 4'd1,
    CLS_OP_IMM = 4'd2,
    CLS_LOAD   = 4'd3,
    CLS_STORE  = 4'd4,
    CLS_BRANCH = 4'd5,
    CLS_LUI    = 4'd6,
    CLS_AUIPC  = 4'd7,
    CLS_JAL    = 4'd8,
    CLS_JALR   = 4'd9
  } cls_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLL   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_SLT   = 4'd8;
  localparam logic [3:0] ALU_SLTU  = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] REG_DMEM = 2'd0;
  localparam logic [1:0] REG_ALU  = 2'd1;
  localparam logic [1:0] REG_PC4  = 2'd2;

  function automatic cls_t opcode_class(input logic [6:0] opc);
    cls_t cls;
    case (opc)
      OPC_OP:     cls = CLS_OP;
      OPC_OP_IMM: cls = CLS_OP_IMM;
      OPC_LOAD:   cls = CLS_LOAD;
      OPC_STORE:  cls = CLS_STORE;
      OPC_BRANCH: cls = CLS_BRANCH;
      OPC_LUI:    cls = CLS_LUI;
      OPC_AUIPC:  cls = CLS_AUIPC;
      OPC_JAL:    cls = CLS_JAL;
      OPC_JALR:   cls = CLS_JALR;
      default:    cls = CLS_NONE;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/alu_decode.sv
// ALU operation select from the registered instruction class, funct3 and ins[30].
module alu_decode
  import riscv_ctrl_pkg::*;
(
  input  cls_t       cls,
  input  logic [2:0] funct3,
  input  logic       ins30,
  output logic [3:0] alu_op
);

  logic is_arith_s;

  // Only OP/OP-IMM use funct3; ins[30] selects SUB for OP only, and SRA for both.
  always_comb begin
    is_arith_s = (cls == CLS_OP) || (cls == CLS_OP_IMM);
    alu_op     = ALU_ADD;
    if (cls == CLS_LUI) begin
      alu_op = ALU_PASSB;
    end else if (is_arith_s) begin
      case (funct3)
        3'd0:    alu_op = (ins30 && (cls == CLS_OP)) ? ALU_SUB : ALU_ADD;
        3'd1:    alu_op = ALU_SLL;
        3'd2:    alu_op = ALU_SLT;
        3'd3:    alu_op = ALU_SLTU;
        3'd4:    alu_op = ALU_XOR;
        3'd5:    alu_op = ins30 ? ALU_SRA : ALU_SRL;
        3'd6:    alu_op = ALU_OR;
        3'd7:    alu_op = ALU_AND;
        default: alu_op = ALU_ADD;
      endcase
    end else begin
      alu_op = ALU_ADD;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control sequencer: walks each instruction through
// FETCH/DECODE/EXEC/MEM/WB with stall-tolerant memory handshakes.
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ins,
  input  logic        beq,
  input  logic        blt,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  output logic        imem_req,
  output logic        irWEN,
  output logic        pcWEN,
  output logic        regWEN,
  output logic [3:0]  aluOp,
  output logic [2:0]  immSel,
  output logic        aSel,
  output logic        bSel,
  output logic        mem_req,
  output logic        memRW,
  output logic [1:0]  regSel,
  output logic        pcSel,
  output logic        brUn,
  output logic        illegal,
  output logic [2:0]  state
);

  state_t     state_r;
  cls_t       cls_r;
  cls_t       dec_cls_s;
  logic [2:0] funct3_r;
  logic       ins30_r;
  logic       taken_s;
  logic [3:0] alu_op_s;
  logic       is_jump_s;
  logic       ins_unused_s;

  assign dec_cls_s    = opcode_class(ins[6:0]);
  assign is_jump_s    = (cls_r == CLS_JAL) || (cls_r == CLS_JALR);
  assign state        = state_r;
  assign ins_unused_s = ^{ins[31], ins[29:15], ins[11:7]};

  alu_decode u_alu_decode (
    .cls    (cls_r),
    .funct3 (funct3_r),
    .ins30  (ins30_r),
    .alu_op (alu_op_s)
  );

  // Sequencer state plus the instruction fields captured in DECODE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      cls_r    <= CLS_NONE;
      funct3_r <= 3'd0;
      ins30_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE:  state_r <= ST_FETCH;
        ST_FETCH: state_r <= imem_ack ? ST_DECODE : ST_FETCH;
        ST_DECODE: begin
          cls_r    <= dec_cls_s;
          funct3_r <= ins[14:12];
          ins30_r  <= ins[30];
          state_r  <= (dec_cls_s == CLS_NONE) ? ST_TRAP : ST_EXEC;
        end
        ST_EXEC: begin
          case (cls_r)
            CLS_BRANCH:          state_r <= ST_FETCH;
            CLS_LOAD, CLS_STORE: state_r <= ST_MEM;
            default:             state_r <= ST_WB;
          endcase
        end
        ST_MEM: begin
          if (dmem_ack) begin
            state_r <= (cls_r == CLS_LOAD) ? ST_WB : ST_FETCH;
          end else begin
            state_r <= ST_MEM;
          end
        end
        ST_WB:   state_r <= ST_FETCH;
        ST_TRAP: state_r <= ST_TRAP;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Branch condition: funct3[2] picks the less-than flag, funct3[0] inverts.
  always_comb begin
    case (funct3_r)
      3'b000:         taken_s = beq;
      3'b001:         taken_s = !beq;
      3'b100, 3'b110: taken_s = blt;
      3'b101, 3'b111: taken_s = !blt;
      default:        taken_s = 1'b0;
    endcase
  end

  // Control outputs; ALU selects stay driven through MEM and WB so the
  // memory address and ALU writeback value remain stable.
  always_comb begin
    imem_req = 1'b0;
    irWEN    = 1'b0;
    pcWEN    = 1'b0;
    regWEN   = 1'b0;
    aluOp    = ALU_ADD;
    immSel   = IMM_I;
    aSel     = 1'b0;
    bSel     = 1'b0;
    mem_req  = 1'b0;
    memRW    = 1'b0;
    regSel   = REG_DMEM;
    pcSel    = 1'b0;
    brUn     = 1'b0;
    illegal  = 1'b0;
    if ((state_r == ST_EXEC) || (state_r == ST_MEM) || (state_r == ST_WB)) begin
      aluOp = alu_op_s;
      bSel  = (cls_r != CLS_OP);
      aSel  = (cls_r == CLS_AUIPC) || (cls_r == CLS_JAL) || (cls_r == CLS_BRANCH);
      case (cls_r)
        CLS_STORE:          immSel = IMM_S;
        CLS_BRANCH:         immSel = IMM_B;
        CLS_LUI, CLS_AUIPC: immSel = IMM_U;
        CLS_JAL:            immSel = IMM_J;
        default:            immSel = IMM_I;
      endcase
    end else begin
      aluOp = ALU_ADD;
    end
    case (state_r)
      ST_FETCH: begin
        imem_req = 1'b1;
        irWEN    = imem_ack;
      end
      ST_EXEC: begin
        if (cls_r == CLS_BRANCH) begin
          brUn  = funct3_r[1];
          pcWEN = 1'b1;
          pcSel = taken_s;
        end else begin
          pcWEN = 1'b0;
        end
      end
      ST_MEM: begin
        mem_req = 1'b1;
        memRW   = (cls_r == CLS_STORE);
        pcWEN   = dmem_ack && (cls_r == CLS_STORE);
      end
      ST_WB: begin
        regWEN = 1'b1;
        pcWEN  = 1'b1;
        pcSel  = is_jump_s;
        if (cls_r == CLS_LOAD) begin
          regSel = REG_DMEM;
        end else if (is_jump_s) begin
          regSel = REG_PC4;
        end else begin
          regSel = REG_ALU;
        end
      end
      ST_TRAP: illegal = 1'b1;
      default: illegal = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench: per-instruction expected cycle scripts built from the
// instruction-level rules, with random memory waits and branch flags.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       imem_req;
    logic       ir_wen;
    logic       pc_wen;
    logic       reg_wen;
    logic [3:0] alu_op;
    logic [2:0] imm_sel;
    logic       a_sel;
    logic       b_sel;
    logic       mem_req;
    logic       mem_rw;
    logic [1:0] reg_sel;
    logic       pc_sel;
    logic       br_un;
    logic       illegal;
    logic [2:0] state;
  } ovec_t;

  typedef struct {
    logic  iack;
    logic  dack;
    ovec_t exp;
  } step_t;

  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2,
                         S_EXEC = 3'd3, S_MEM = 3'd4, S_WB = 3'd5, S_TRAP = 3'd6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ins = 32'd0;
  logic        beq = 1'b0, blt = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0;
  logic        imem_req, irWEN, pcWEN, regWEN, aSel, bSel, mem_req, memRW, pcSel, brUn, illegal;
  logic [3:0]  aluOp;
  logic [2:0]  immSel, state;
  logic [1:0]  regSel;
  ovec_t       obs;
  int          checks = 0;
  int          errors = 0;
  step_t       script[$];

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ins(ins), .beq(beq), .blt(blt),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req), .irWEN(irWEN),
    .pcWEN(pcWEN), .regWEN(regWEN), .aluOp(aluOp), .immSel(immSel), .aSel(aSel),
    .bSel(bSel), .mem_req(mem_req), .memRW(memRW), .regSel(regSel), .pcSel(pcSel),
    .brUn(brUn), .illegal(illegal), .state(state)
  );

  assign obs = {imem_req, irWEN, pcWEN, regWEN, aluOp, immSel, aSel, bSel,
                mem_req, memRW, regSel, pcSel, brUn, illegal, state};

  // ALU-side controls an instruction needs from EXEC onward.
  function automatic ovec_t alu_view(input logic [31:0] instr);
    ovec_t      v;
    logic [3:0] tab [8];
    logic [2:0] f3;
    v   = '0;
    tab = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
    f3  = instr[14:12];
    case (instr[6:0])
      7'b0110011: begin
        v.alu_op = tab[f3];
        if (instr[30] && f3 == 3'd0) v.alu_op = 4'd1;
        if (instr[30] && f3 == 3'd5) v.alu_op = 4'd7;
      end
      7'b0010011: begin
        v.b_sel  = 1'b1;
        v.alu_op = tab[f3];
        if (instr[30] && f3 == 3'd5) v.alu_op = 4'd7;
      end
      7'b0000011, 7'b1100111: v.b_sel = 1'b1;
      7'b0100011: begin v.b_sel = 1'b1; v.imm_sel = 3'd1; end
      7'b0010111: begin v.a_sel = 1'b1; v.b_sel = 1'b1; v.imm_sel = 3'd3; end
      7'b0110111: begin v.b_sel = 1'b1; v.imm_sel = 3'd3; v.alu_op = 4'd10; end
      7'b1101111: begin v.a_sel = 1'b1; v.b_sel = 1'b1; v.imm_sel = 3'd4; end
      7'b1100011: begin v.a_sel = 1'b1; v.b_sel = 1'b1; v.imm_sel = 3'd2; end
      default: ;
    endcase
    return v;
  endfunction

  task automatic push(input logic iack, input logic dack, input ovec_t v);
    step_t s;
    s.iack = iack; s.dack = dack; s.exp = v;
    script.push_back(s);
  endtask

  // Expected per-cycle outputs for one instruction with iw fetch waits and dw data waits.
  task automatic build(input logic [31:0] instr, input int iw, input int dw,
                       input logic b_eq, input logic b_lt);
    ovec_t base, v;
    logic [6:0] opc;
    logic [2:0] f3;
    logic taken, jump;
    script.delete();
    opc = instr[6:0];
    f3  = instr[14:12];
    for (int i = 0; i <= iw; i++) begin
      v = '0; v.imem_req = 1'b1; v.ir_wen = (i == iw); v.state = S_FETCH;
      push(i == iw, 1'b0, v);
    end
    v = '0; v.state = S_DECODE;
    push(1'b0, 1'b0, v);
    if (!(opc inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                      7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111})) return;
    base = alu_view(instr);
    v = base; v.state = S_EXEC;
    if (opc == 7'b1100011) begin
      case (f3)
        3'd0: taken = b_eq;
        3'd1: taken = !b_eq;
        3'd4, 3'd6: taken = b_lt;
        3'd5, 3'd7: taken = !b_lt;
        default: taken = 1'b0;
      endcase
      v.br_un = f3[1]; v.pc_wen = 1'b1; v.pc_sel = taken;
      push(1'b0, 1'b0, v);
      return;
    end
    push(1'b0, 1'b0, v);
    if (opc == 7'b0000011 || opc == 7'b0100011) begin
      for (int i = 0; i <= dw; i++) begin
        v = base; v.state = S_MEM; v.mem_req = 1'b1; v.mem_rw = (opc == 7'b0100011);
        v.pc_wen = (opc == 7'b0100011) && (i == dw);
        push(1'b0, i == dw, v);
      end
      if (opc == 7'b0100011) return;
    end
    jump = (opc == 7'b1101111) || (opc == 7'b1100111);
    v = base; v.state = S_WB; v.reg_wen = 1'b1; v.pc_wen = 1'b1; v.pc_sel = jump;
    v.reg_sel = (opc == 7'b0000011) ? 2'd0 : (jump ? 2'd2 : 2'd1);
    push(1'b0, 1'b0, v);
  endtask

  // Plays the first n script steps (all if n < 0), comparing every cycle.
  task automatic run_script(input string name, input logic [31:0] instr, input int n,
                            input logic b_eq, input logic b_lt, output int mem_cycles);
    int lim;
    lim = (n < 0) ? script.size() : n;
    mem_cycles = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      imem_ack = script[i].iack;
      dmem_ack = script[i].dack;
      beq = b_eq;
      blt = b_lt;
      if (script[i].iack) ins = instr;
      #1;
      checks++;
      if (obs !== script[i].exp) begin
        errors++;
        $display("FAIL %s step %0d: got %h (state %0d) expected %h (state %0d)",
                 name, i, obs, obs.state, script[i].exp, script[i].exp.state);
      end
      if (obs.mem_req) mem_cycles++;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    #1; checks++;
    if (obs !== '0) begin errors++; $display("FAIL reset_held: got %h expected 0", obs); end
    @(negedge clk);
    rst_n = 1'b1;
    #1; checks++;
    if (obs !== '0) begin errors++; $display("FAIL reset_idle: got %h expected 0", obs); end
  endtask

  task automatic test_add;
    int m;
    build(32'h002081B3, 0, 0, 1'b0, 1'b0);
    run_script("add", 32'h002081B3, -1, 1'b0, 1'b0, m);
    @(negedge clk);
    imem_ack = 1'b0;
    #1; checks++;
    if (obs.state !== S_FETCH || obs.imem_req !== 1'b1) begin
      errors++; $display("FAIL add_next_fetch: got state %0d req %b expected 1 1", obs.state, obs.imem_req);
    end
  endtask

  task automatic test_lw;
    int m;
    build(32'h0040A183, 0, 3, 1'b0, 1'b0);
    run_script("lw", 32'h0040A183, -1, 1'b0, 1'b0, m);
    checks++;
    if (m != 4) begin errors++; $display("FAIL lw_mem_cycles: got %0d expected 4", m); end
    checks++;
    if (script.size() != 8) begin errors++; $display("FAIL lw_total: got %0d expected 8", script.size()); end
  endtask

  task automatic test_branch;
    int m;
    build(32'h00209463, 0, 0, 1'b1, 1'b0);
    run_script("bne_eq", 32'h00209463, -1, 1'b1, 1'b0, m);
    build(32'h00209463, 1, 0, 1'b0, 1'b1);
    run_script("bne_ne", 32'h00209463, -1, 1'b0, 1'b1, m);
    build(32'h0020F463, 0, 0, 1'b0, 1'b1);
    run_script("bgeu", 32'h0020F463, -1, 1'b0, 1'b1, m);
  endtask

  task automatic test_jal;
    int m;
    build(32'h008000EF, 0, 0, 1'b0, 1'b0);
    run_script("jal", 32'h008000EF, -1, 1'b0, 1'b0, m);
  endtask

  task automatic test_random;
    logic [6:0]  opcs [9];
    logic [2:0]  bf3 [6];
    logic [31:0] instr;
    logic        e, l;
    int          m, k;
    opcs = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
             7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};
    bf3  = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    for (int n = 0; n < 60; n++) begin
      k = $urandom_range(0, 8);
      instr = $urandom;
      instr[6:0] = opcs[k];
      if (k == 4) instr[14:12] = bf3[$urandom_range(0, 5)];
      if (k == 2 || k == 3) instr[14:12] = 3'd2;
      e = 1'($urandom_range(0, 1));
      l = 1'($urandom_range(0, 1));
      build(instr, $urandom_range(0, 2), $urandom_range(0, 3), e, l);
      run_script("random", instr, -1, e, l, m);
    end
  endtask

  task automatic test_reset_mid_mem;
    int m;
    build(32'h00112223, 0, 5, 1'b0, 1'b0);
    run_script("sw_pre_reset", 32'h00112223, 5, 1'b0, 1'b0, m);
    #2 rst_n = 1'b0;
    #1; checks++;
    if (obs !== '0) begin errors++; $display("FAIL midmem_async: got %h expected 0", obs); end
    @(posedge clk);
    #1; checks++;
    if (obs !== '0) begin errors++; $display("FAIL midmem_hold: got %h expected 0", obs); end
    @(negedge clk);
    rst_n = 1'b1; dmem_ack = 1'b0; imem_ack = 1'b0;
    @(negedge clk);
    #1; checks++;
    if (obs.state !== S_FETCH || obs.imem_req !== 1'b1 || obs.pc_wen !== 1'b0) begin
      errors++; $display("FAIL midmem_restart: got %h expected FETCH with imem_req", obs);
    end
    build(32'h40208133, 0, 0, 1'b0, 1'b0);
    run_script("sub_after_reset", 32'h40208133, -1, 1'b0, 1'b0, m);
  endtask

  task automatic test_trap;
    int    m, bad;
    ovec_t t;
    build(32'h0000007F, 0, 0, 1'b0, 1'b0);
    run_script("trap_fetch", 32'h0000007F, -1, 1'b0, 1'b0, m);
    t = '0; t.illegal = 1'b1; t.state = S_TRAP;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      imem_ack = 1'b0;
      #1;
      if (obs !== t) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL trap_hold: got %0d bad cycles (last %h) expected 0", bad, obs); end
    test_reset();
    checks++;
    if (illegal !== 1'b0) begin errors++; $display("FAIL trap_cleared: got %b expected 0", illegal); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw();
    test_branch();
    test_jal();
    test_random();
    test_reset_mid_mem();
    test_trap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control sequencer for the RV32I datapath (PC, IMem, RegFile, ImmSinExt, ALU, BrComp, DMem, select muxes). It replaces single-cycle combinational control: it walks each instruction through FETCH/DECODE/EXEC/MEM/WB states and handshakes with instruction and data memory that may stall. It drives the same control fields the datapath muxes consume, plus explicit PC and IR write enables.

## Interface
- No parameters; encodings are fixed in the shared package.
- clk  in  1  datapath clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ins  in  32  instruction register output; stable from the cycle after irWEN
- beq  in  1  BrComp equal flag
- blt  in  1  BrComp less-than flag (signedness per brUn)
- imem_ack  in  1  instruction memory data valid; may arrive in the same cycle as imem_req
- dmem_ack  in  1  data memory access done; may arrive in the same cycle as mem_req
- imem_req  out  1  instruction fetch request at address PC
- irWEN  out  1  load ins register
- pcWEN  out  1  load PC from pcSel mux
- regWEN  out  1  RegFile write
- aluOp  out  4  ALU operation
- immSel  out  3  immediate format: I=0, S=1, B=2, U=3, J=4
- aSel  out  1  0 = rs1, 1 = PC
- bSel  out  1  0 = rs2, 1 = immediate
- mem_req  out  1  data memory request
- memRW  out  1  1 = write (store), 0 = read
- regSel  out  2  writeback source: 0 = DMem, 1 = ALU, 2 = PC+4
- pcSel  out  1  0 = PC+4, 1 = ALU
- brUn  out  1  unsigned compare
- illegal  out  1  sticky unsupported-opcode flag
- state  out  3  current state, for debug and bench

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- IDLE:
  - Reset state; all outputs 0.
  - Always goes to FETCH next cycle.
- FETCH:
  - imem_req = 1 until imem_ack.
  - On imem_ack: irWEN = 1 for that cycle, then DECODE.
  - Holds without limit while ack is low.
- DECODE:
  - One cycle. Registers the instruction class from ins[6:0], plus funct3 and ins[30].
  - Supported classes:
    - OP (0110011), OP-IMM (0010011), LOAD (0000011, LW), STORE (0100011, SW)
    - BRANCH (1100011, all six conditions)
    - LUI (0110111), AUIPC (0010111), JAL (1101111), JALR (1100111)
  - Any other opcode goes to TRAP.
- EXEC:
  - aSel/bSel/immSel/aluOp are set per class:
    - OP: rs1 op rs2
    - OP-IMM: rs1 op imm-I. ins[30] is used only for SRAI.
    - LOAD, JALR: rs1 + imm-I
    - STORE: rs1 + imm-S
    - AUIPC: PC + imm-U
    - LUI: PASSB imm-U
    - JAL, BRANCH: PC + imm
  - BRANCH resolves in EXEC:
    - brUn = funct3[1].
    - taken: BEQ = beq, BNE = !beq, BLT/BLTU = blt, BGE/BGEU = !blt.
    - pcWEN = 1; pcSel = taken.
    - Next state FETCH.
  - LOAD/STORE go to MEM. All other classes go to WB.
- MEM:
  - mem_req = 1; memRW = 1 for STORE.
  - ALU controls stay as in EXEC, so the address stays stable.
  - Holds until dmem_ack.
  - On dmem_ack, LOAD goes to WB. STORE sets pcWEN = 1, pcSel = 0, and goes to FETCH.
- WB:
  - regWEN = 1 and pcWEN = 1 for one cycle; next state FETCH.
  - regSel: 0 for LOAD, 2 for JAL/JALR, 1 otherwise.
  - pcSel = 1 for JAL/JALR, with ALU controls held from EXEC; 0 otherwise.
- TRAP:
  - illegal = 1. No enables asserted.
  - Absorbing state; exits only on reset.
- Outputs are decoded from state plus the registered class. aluOp mapping:
  - ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SRA 7, SLT 8, SLTU 9, PASSB 10.

## Timing
- Reset:
  - rst_n low forces IDLE immediately, from any state including mid-MEM or mid-FETCH.
  - All outputs are 0 while reset is asserted. illegal is cleared.
  - Any in-flight request is dropped; memories must tolerate a request deasserting without ack.
- First imem_req comes 1 cycle after rst_n rises (IDLE→FETCH).
- Cycles per instruction with zero-wait memory (ack same cycle as req):
  - BRANCH 3
  - OP, OP-IMM, LUI, AUIPC, JAL, JALR 4
  - STORE 4
  - LOAD 5
- Each memory wait cycle adds 1.
- At most one of regWEN/pcWEN-causing states is active per cycle.
- The PC changes exactly once per instruction. irWEN is never asserted outside FETCH.
- imem_req and mem_req are never asserted in the same cycle.

## Structure
- Package riscv_ctrl_pkg holds:
  - state enum
  - opcode constants
  - aluOp, immSel and regSel encodings
- Sub-module alu_decode (combinational): class, funct3 and ins[30] in; aluOp out.
- FSM and output decode are in multicycle_ctrl.

## Test plan
- Reset then zero-wait fetch of ADD (0x002081B3):
  - state sequence IDLE, FETCH, DECODE, EXEC, WB.
  - WB has regWEN = 1, regSel = 1, pcWEN = 1, pcSel = 0, aluOp = 0.
- LW with dmem_ack delayed 3 cycles:
  - mem_req held 4 cycles with memRW = 0.
  - then WB with regSel = 0.
  - total 8 cycles.
- BNE with beq = 1: EXEC has pcWEN = 1, pcSel = 0. Same with beq = 0: pcSel = 1. BGEU: brUn = 1.
- JAL: EXEC has aSel = 1, bSel = 1, immSel = 4; WB has regSel = 2, pcSel = 1, regWEN = 1.
- Opcode 0x7F: DECODE → TRAP, illegal = 1, imem_req stays 0 for 20 cycles; reset clears illegal.
- rst_n pulsed low mid-MEM of an SW:
  - mem_req drops asynchronously, state = IDLE, no pcWEN.
  - after release, FETCH restarts.
